// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Round-robin arbiter for the single register-file write port,
//            with in-flight register mask and saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     nRESET,
    input  logic                     arb_en,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     write_en,
    output logic [ADDR_W-1:0]        write_addr,
    output logic [DATA_W-1:0]        write_data,
    output logic [15:0]              pend_mask,
    output logic [7:0]               busy_cnt
);

    localparam int c_ptr_w = $clog2(NREQ);

    logic [c_ptr_w-1:0] r_ptr;
    logic               r_write_en;
    logic [ADDR_W-1:0]  r_write_addr;
    logic [DATA_W-1:0]  r_write_data;
    logic [15:0]        r_pend_mask;
    logic [7:0]         r_busy_cnt;

    logic [NREQ-1:0]    w_gnt;
    logic               w_found;
    logic [c_ptr_w-1:0] w_gnt_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_busy;

    // Search order ptr, ptr+1, ... wrapping at NREQ; the first requester hit wins.
    always_comb begin
        w_gnt      = '0;
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        if (arb_en && nRESET) begin
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!w_found && req[i] && (i == ((int'(r_ptr) + k) % NREQ))) begin
                        w_found    = 1'b1;
                        w_gnt[i]   = 1'b1;
                        w_gnt_idx  = c_ptr_w'(i);
                        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                        w_sel_data = req_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // A stall cycle: something is requesting but not everything requesting got served.
    always_comb begin
        w_busy = (|req) && (!arb_en || (|(req & ~w_gnt)));
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_ptr        <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_pend_mask  <= '0;
            r_busy_cnt   <= '0;
        end else begin
            r_write_en <= w_found;
            if (w_found) begin
                r_ptr        <= (w_gnt_idx == c_ptr_w'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                r_write_addr <= w_sel_addr;
                r_write_data <= w_sel_data;
                r_pend_mask  <= 16'd1 << w_sel_addr;
            end else begin
                r_pend_mask  <= '0;
            end
            if (w_busy && (r_busy_cnt != 8'hFF)) begin
                r_busy_cnt <= r_busy_cnt + 8'd1;
            end
        end
    end

    assign gnt        = w_gnt;
    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign pend_mask  = r_pend_mask;
    assign busy_cnt   = r_busy_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Directed self-checking bench for regfile_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic                   clk;
    logic                   nRESET;
    logic                   arb_en;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   write_en;
    logic [ADDR_W-1:0]      write_addr;
    logic [DATA_W-1:0]      write_data;
    logic [15:0]            pend_mask;
    logic [7:0]             busy_cnt;

    int checks = 0;
    int errors = 0;
    int exp_busy = 0;

    regfile_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .arb_en     (arb_en),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .pend_mask  (pend_mask),
        .busy_cnt   (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRESET = 1'b0; arb_en = 1'b1; req = 3'b111;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt); end
        tick();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", write_en); end
        checks++; if (write_addr !== 4'h0 || write_data !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h/%h exp 0/0", write_addr, write_data); end
        checks++; if (pend_mask !== 16'h0) begin errors++; $display("FAIL reset_pend got %h exp 0000", pend_mask); end
        checks++; if (busy_cnt !== 8'd0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy_cnt); end
        nRESET = 1'b1; req = 3'b000;
        exp_busy = 0;
    endtask

    task automatic test_single();
        req_addr[1*ADDR_W +: ADDR_W] = 4'h5;
        req_data[1*DATA_W +: DATA_W] = 16'h9696;
        req = 3'b010;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got %b exp 010", gnt); end
        tick();
        req = 3'b000;
        checks++; if (write_en !== 1'b1 || write_addr !== 4'h5 || write_data !== 16'h9696) begin
            errors++; $display("FAIL single_write got en=%b a=%h d=%h exp en=1 a=5 d=9696", write_en, write_addr, write_data); end
        checks++; if (pend_mask !== 16'h0020) begin errors++; $display("FAIL single_pend got %h exp 0020", pend_mask); end
        tick();
        checks++; if (write_en !== 1'b0 || pend_mask !== 16'h0) begin errors++; $display("FAIL single_done got en=%b pend=%h exp en=0 pend=0000", write_en, pend_mask); end
        checks++; if (write_addr !== 4'h5 || write_data !== 16'h9696) begin errors++; $display("FAIL single_hold got %h/%h exp 5/9696", write_addr, write_data); end
        checks++; if (busy_cnt !== 8'(exp_busy)) begin errors++; $display("FAIL single_busy got %0d exp %0d", busy_cnt, exp_busy); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_g;
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        exp_busy = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = 4'(i + 1);
            req_data[i*DATA_W +: DATA_W] = 16'h1111 * 16'(i + 1);
        end
        req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_g = 3'b001 << (c % 3);
            #1;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL fair_gnt[%0d] got %b exp %b", c, gnt, exp_g); end
            if (c > 0) begin
                checks++; if (write_en !== 1'b1 || write_addr !== 4'(((c - 1) % 3) + 1)) begin
                    errors++; $display("FAIL fair_write[%0d] got en=%b a=%h exp en=1 a=%0d", c, write_en, write_addr, ((c - 1) % 3) + 1); end
            end
            tick();
            exp_busy++;
        end
        req = 3'b000;
        checks++; if (write_addr !== 4'h3 || write_data !== 16'h3333) begin errors++; $display("FAIL fair_last got %h/%h exp 3/3333", write_addr, write_data); end
        checks++; if (busy_cnt !== 8'(exp_busy)) begin errors++; $display("FAIL fair_busy got %0d exp %0d", busy_cnt, exp_busy); end
    endtask

    task automatic test_wrap();
        // ptr is 0 here; a grant to requester 1 moves it to 2.
        req = 3'b010;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wrap_setup got %b exp 010", gnt); end
        tick();
        req = 3'b011;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wrap_gnt0 got %b exp 001", gnt); end
        tick();
        exp_busy++;
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wrap_gnt1 got %b exp 010", gnt); end
        checks++; if (write_addr !== 4'h1 || pend_mask !== 16'h0002) begin errors++; $display("FAIL wrap_write0 got a=%h pend=%h exp a=1 pend=0002", write_addr, pend_mask); end
        tick();
        exp_busy++;
        req = 3'b000;
        checks++; if (write_addr !== 4'h2 || write_data !== 16'h2222) begin errors++; $display("FAIL wrap_write1 got %h/%h exp 2/2222", write_addr, write_data); end
        checks++; if (busy_cnt !== 8'(exp_busy)) begin errors++; $display("FAIL wrap_busy got %0d exp %0d", busy_cnt, exp_busy); end
    endtask

    task automatic test_arb_en();
        int pulses;
        // ptr is 2 here; search 2,0 finds requester 0.
        req = 3'b001; arb_en = 1'b1;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL gate_first got %b exp 001", gnt); end
        tick();
        arb_en = 1'b0; req = 3'b100;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL gate_gnt[%0d] got %b exp 000", c, gnt); end
            if (write_en === 1'b1) pulses++;
            tick();
            exp_busy++;
        end
        if (write_en === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL gate_pulses got %0d exp 1", pulses); end
        checks++; if (write_addr !== 4'h1) begin errors++; $display("FAIL gate_addr got %h exp 1", write_addr); end
        checks++; if (busy_cnt !== 8'(exp_busy)) begin errors++; $display("FAIL gate_busy got %0d exp %0d", busy_cnt, exp_busy); end
        arb_en = 1'b1;
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL gate_resume got %b exp 100", gnt); end
        tick();
        req = 3'b000;
    endtask

    task automatic test_saturate_reset();
        arb_en = 1'b0; req = 3'b100;
        repeat (300) tick();
        exp_busy = (exp_busy + 300 > 255) ? 255 : exp_busy + 300;
        checks++; if (busy_cnt !== 8'(exp_busy)) begin errors++; $display("FAIL sat_busy got %0d exp %0d", busy_cnt, exp_busy); end
        // ptr is 0 after the last grant to requester 2.
        req_addr[0 +: ADDR_W] = 4'hA;
        req_data[0 +: DATA_W] = 16'hBEEF;
        arb_en = 1'b1; req = 3'b001;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rst_mid_gnt got %b exp 001", gnt); end
        tick();
        req = 3'b101;
        checks++; if (write_en !== 1'b1 || pend_mask !== 16'h0400) begin errors++; $display("FAIL rst_mid_write got en=%b pend=%h exp en=1 pend=0400", write_en, pend_mask); end
        nRESET = 1'b0;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_mid_gnt_low got %b exp 000", gnt); end
        tick();
        checks++; if (write_en !== 1'b0 || pend_mask !== 16'h0 || busy_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_mid_cancel got en=%b pend=%h busy=%0d exp 0/0000/0", write_en, pend_mask, busy_cnt); end
        nRESET = 1'b1;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rst_rearb got %b exp 001", gnt); end
        tick();
        req = 3'b000;
        checks++; if (write_en !== 1'b1 || write_addr !== 4'hA || write_data !== 16'hBEEF) begin
            errors++; $display("FAIL rst_rearb_write got en=%b a=%h d=%h exp 1/a/beef", write_en, write_addr, write_data); end
        tick();
    endtask

    initial begin
        nRESET   = 1'b0;
        arb_en   = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_arb_en();
        test_saturate_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
